btb_update_ctrl: RTL

BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

---
 rtl/btb_update_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - Branch target buffer update controller with resolved-branch queue
module btb_update_ctrl #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         upd_valid,
    output logic         upd_ready,
    input  logic [31:0]  upd_pc,
    input  logic [31:0]  upd_target,
    input  logic         upd_taken,
    output logic [2:0]   update_index,
    input  logic [127:0] update_set,
    output logic         write_enable,
    output logic [2:0]   write_index,
    output logic [127:0] write_set,
    output logic         busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Queue entry: {pc[31:2], target[31:2], taken}; byte-offset bits never matter
    logic [60:0]      r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_unused_low_bits;

    logic [60:0] w_head;
    logic [26:0] w_tag;
    logic [2:0]  w_head_index;
    logic [29:0] w_head_target;
    logic        w_head_taken;

    logic [63:0] w_way0;
    logic [63:0] w_way1;
    logic        w_hit0;
    logic        w_hit1;
    logic        w_lru;

    logic        w_need_write;
    logic        w_sel_way;
    logic [63:0] w_upd_way;
    logic [1:0]  w_ctr;
    logic [63:0] w_new_way0;
    logic [63:0] w_new_way1;

    logic         r_write_enable;
    logic [2:0]   r_write_index;
    logic [127:0] r_write_set;

    assign w_unused_low_bits = ^{upd_pc[1:0], upd_target[1:0]};

    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    // A full queue refuses new entries even when the head pops this same cycle
    assign w_push  = upd_valid && !w_full;
    assign w_pop   = (r_state == S_WRITE);

    assign w_head        = r_fifo[r_rd_ptr];
    assign w_tag         = w_head[60:34];
    assign w_head_index  = w_head[33:31];
    assign w_head_target = w_head[30:1];
    assign w_head_taken  = w_head[0];

    assign w_way0 = update_set[63:0];
    assign w_way1 = update_set[127:64];
    assign w_hit0 = w_way0[63] && (w_way0[62:36] == w_tag);
    assign w_hit1 = w_way1[63] && (w_way1[62:36] == w_tag);
    assign w_lru  = w_way0[0];

    assign upd_ready    = !w_full;
    assign update_index = w_empty ? 3'd0 : w_head_index;
    assign busy         = !w_empty || (r_state != S_IDLE);
    assign write_enable = r_write_enable;
    assign write_index  = r_write_index;
    assign write_set    = r_write_set;

    // Queue occupancy after this cycle's push and pop
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    // Queue payload storage; contents are only meaningful below the occupancy count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {upd_pc[31:2], upd_target[31:2], upd_taken};
        end
    end

    // Queue pointers and occupancy; reset empties the queue at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: one read-modify-write pair per queued update
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty) w_state_next = S_READ;
            S_READ:  w_state_next = S_WRITE;
            S_WRITE: w_state_next = (w_count_next != '0) ? S_READ : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // New set contents from the current storage set and the head update
    always_comb begin
        w_need_write = 1'b0;
        w_sel_way    = 1'b0;
        w_upd_way    = w_way0;
        w_ctr        = 2'b00;
        w_new_way0   = w_way0;
        w_new_way1   = w_way1;
        if (w_hit0 || w_hit1) begin
            w_need_write = 1'b1;
            w_sel_way    = !w_hit0;
            w_upd_way    = w_sel_way ? w_way1 : w_way0;
            w_ctr        = w_upd_way[5:4];
            if (w_head_taken) begin
                if (w_ctr != 2'b11) begin
                    w_ctr = w_ctr + 2'b01;
                end
                w_upd_way[35:6] = w_head_target;
            end else if (w_ctr != 2'b00) begin
                w_ctr = w_ctr - 2'b01;
            end
            w_upd_way[5:4] = w_ctr;
        end else if (w_head_taken) begin
            w_need_write = 1'b1;
            if (!w_way0[63]) begin
                w_sel_way = 1'b0;
            end else if (!w_way1[63]) begin
                w_sel_way = 1'b1;
            end else begin
                w_sel_way = w_lru;
            end
            w_upd_way = {1'b1, w_tag, w_head_target, 2'b10, 4'b0000};
        end
        if (w_sel_way) begin
            w_new_way1 = w_upd_way;
        end else begin
            w_new_way0 = w_upd_way;
        end
        // The LRU bit lives in way0 and always points away from the touched way
        if (w_need_write) begin
            w_new_way0[0] = ~w_sel_way;
        end
    end

    // Write port: captured during READ, strobed for the single WRITE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write_enable <= 1'b0;
            r_write_index  <= 3'd0;
            r_write_set    <= '0;
        end else if (r_state == S_READ) begin
            r_write_enable <= w_need_write;
            r_write_index  <= w_head_index;
            r_write_set    <= {w_new_way1, w_new_way0};
        end else begin
            r_write_enable <= 1'b0;
        end
    end

endmodule
